// File: rtl/pmc_pkg.sv
// rtl/pmc_pkg.sv - shared state type, default sizes and select-width helper for the PMC bank
package pmc_pkg;

  typedef enum logic {
    PMC_STOPPED = 1'b0,
    PMC_RUNNING = 1'b1
  } pmc_state_t;

  localparam int PMC_DEF_NUM_EVENTS = 8;
  localparam int PMC_DEF_CNT_W      = 32;
  localparam int PMC_DEF_INC_W      = 2;
  localparam int PMC_DEF_OUT_W      = 256;

  // Index width that addresses n channels plus the trailing cycle counter.
  function automatic int pmc_sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pmc_channel.sv
// rtl/pmc_channel.sv - one live/shadow counter pair with sticky overflow flag
// Wraps modulo 2^CNT_W by default; saturates at all-ones when PMC_SATURATE_EN is defined.
module pmc_channel #(
  parameter int CNT_W = 32,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic             snap,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, live} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};

  // Shadow takes the pre-update live value, so a snap alongside clear keeps the old count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live   <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (snap) shadow <= live;
      if (clear) begin
        live <= '0;
        ovf  <= 1'b0;
      end else if (run) begin
`ifdef PMC_SATURATE_EN
        live <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
        live <= sum[CNT_W-1:0];
`endif
        if (sum[CNT_W]) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmc_counter_bank.sv
// rtl/pmc_counter_bank.sv - parametrised PMC bank: run/stop FSM, channel array, shadow read mux
// Channel overflow mode follows PMC_SATURATE_EN (see pmc_channel).
module pmc_counter_bank
  import pmc_pkg::*;
#(
  parameter int NUM_EVENTS = PMC_DEF_NUM_EVENTS,
  parameter int CNT_W      = PMC_DEF_CNT_W,
  parameter int INC_W      = PMC_DEF_INC_W,
  parameter int OUT_W      = PMC_DEF_OUT_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pmc_en,
  input  logic                                clear_req,
  input  logic                                snap_req,
  input  logic [NUM_EVENTS*INC_W-1:0]         event_inc_in,
  input  logic [pmc_sel_w(NUM_EVENTS)-1:0]    rd_sel,
  output logic [OUT_W-1:0]                    rd_data_out,
  output logic                                rd_ovf_out,
  output logic                                ovf_any_out,
  output logic                                running_out
);

  localparam int SEL_W = pmc_sel_w(NUM_EVENTS);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_EVENTS);

  pmc_state_t state, state_nxt;
  logic       run;

  logic [CNT_W-1:0]    shadow_arr  [0:NUM_EVENTS];
  logic [CNT_W-1:0]    unused_live [0:NUM_EVENTS];
  logic [NUM_EVENTS:0] ovf_vec;

  assign run         = (state == PMC_RUNNING);
  assign running_out = run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PMC_STOPPED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pmc_en) state_nxt = run ? PMC_STOPPED : PMC_RUNNING;
  end

  // Index NUM_EVENTS is the enabled-cycle counter, fed a constant increment of one.
  for (genvar i = 0; i <= NUM_EVENTS; i++) begin : g_ch
    logic [INC_W-1:0] inc;
    if (i < NUM_EVENTS) begin : g_evt
      assign inc = event_inc_in[i*INC_W +: INC_W];
    end else begin : g_cyc
      assign inc = INC_W'(1);
    end

    pmc_channel #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .clear  (clear_req),
      .snap   (snap_req),
      .inc    (inc),
      .live   (unused_live[i]),
      .shadow (shadow_arr[i]),
      .ovf    (ovf_vec[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_out <= '0;
      rd_ovf_out  <= 1'b0;
      ovf_any_out <= 1'b0;
    end else begin
      if (rd_sel <= LAST_SEL) begin
        rd_data_out <= OUT_W'(shadow_arr[rd_sel]);
        rd_ovf_out  <= ovf_vec[rd_sel];
      end else begin
        rd_data_out <= '0;
        rd_ovf_out  <= 1'b0;
      end
      ovf_any_out <= |ovf_vec;
    end
  end

endmodule

// File: tb/tb_pmc_counter_bank.sv
// tb/tb_pmc_counter_bank.sv - randomized scoreboard bench for pmc_counter_bank
module tb_pmc_counter_bank;

  localparam int N  = 8;
  localparam int CW = 8;
  localparam int IW = 2;
  localparam int OW = 32;
  localparam int SW = $clog2(N + 1);
  localparam longint MAXV = (longint'(1) << CW) - 1;
`ifdef PMC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk, reset, pmc_en, clear_req, snap_req;
  logic [N*IW-1:0] event_inc_in;
  logic [SW-1:0] rd_sel;
  logic [OW-1:0] rd_data_out;
  logic          rd_ovf_out, ovf_any_out, running_out;

  pmc_counter_bank #(
    .NUM_EVENTS (N),
    .CNT_W      (CW),
    .INC_W      (IW),
    .OUT_W      (OW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pmc_en       (pmc_en),
    .clear_req    (clear_req),
    .snap_req     (snap_req),
    .event_inc_in (event_inc_in),
    .rd_sel       (rd_sel),
    .rd_data_out  (rd_data_out),
    .rd_ovf_out   (rd_ovf_out),
    .ovf_any_out  (ovf_any_out),
    .running_out  (running_out)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          rovf;
    logic          any;
    logic          run;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  longint live_m   [N+1];
  longint shadow_m [N+1];
  bit     ovf_m    [N+1];
  bit     run_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= N; i++) begin
      live_m[i]   = 0;
      shadow_m[i] = 0;
      ovf_m[i]    = 1'b0;
    end
    run_m = 1'b0;
  endtask

  // Drives one cycle, predicts the registered outputs after the edge, and queues them.
  task automatic cycle(input bit en, input bit clr, input bit snp, input logic [N*IW-1:0] inc,
                       input int sel, input bit use_const, input longint cdata, input bit covf,
                       input string name);
    exp_t e;
    bit   any;
    pmc_en       = en;
    clear_req    = clr;
    snap_req     = snp;
    event_inc_in = inc;
    rd_sel       = SW'(sel);
    any = 1'b0;
    for (int i = 0; i <= N; i++) any |= ovf_m[i];
    if (sel <= N) begin
      e.data = OW'(shadow_m[sel]);
      e.rovf = ovf_m[sel];
    end else begin
      e.data = '0;
      e.rovf = 1'b0;
    end
    if (use_const) begin
      e.data = OW'(cdata);
      e.rovf = covf;
    end
    e.any  = any;
    e.name = name;
    for (int i = 0; i <= N; i++) begin
      longint step, s;
      if (snp) shadow_m[i] = live_m[i];
      if (clr) begin
        live_m[i] = 0;
        ovf_m[i]  = 1'b0;
      end else if (run_m) begin
        step = (i < N) ? longint'(inc[i*IW +: IW]) : 1;
        s    = live_m[i] + step;
        if (s > MAXV) begin
          ovf_m[i]  = 1'b1;
          live_m[i] = SAT ? MAXV : s - (MAXV + 1);
        end else begin
          live_m[i] = s;
        end
      end
    end
    if (en) run_m = !run_m;
    e.run = run_m;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({e.name, "_data"}, rd_data_out, e.data);
      check_val({e.name, "_rovf"}, OW'(rd_ovf_out), OW'(e.rovf));
      check_val({e.name, "_any"}, OW'(ovf_any_out), OW'(e.any));
      check_val({e.name, "_run"}, OW'(running_out), OW'(e.run));
    end
  end

  initial begin
    logic [N*IW-1:0] inc2, inc3, inc1, r;
    reset = 1'b0; pmc_en = 1'b0; clear_req = 1'b0; snap_req = 1'b0;
    event_inc_in = '0; rd_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_data", rd_data_out, '0);
    check_val("rst_rovf", OW'(rd_ovf_out), '0);
    check_val("rst_any", OW'(ovf_any_out), '0);
    check_val("rst_run", OW'(running_out), '0);
    reset = 1'b1;

    repeat (10) cycle(0, 0, 0, '1, 0, 0, 0, 0, "t1_idle");
    cycle(0, 0, 1, '0, 0, 0, 0, 0, "t1_snap");
    cycle(0, 0, 0, '0, 0, 1, 0, 0, "t1_ch0");

    inc2 = '0; inc2[1:0] = 2'd1; inc2[3:2] = 2'd3;
    cycle(1, 0, 0, inc2, 0, 0, 0, 0, "t2_start");
    repeat (4) cycle(0, 0, 0, inc2, 0, 0, 0, 0, "t2_run");
    cycle(1, 0, 0, inc2, 0, 0, 0, 0, "t2_stop");
    cycle(0, 0, 1, '0, 0, 0, 0, 0, "t2_snap");
    cycle(0, 0, 0, '0, 0, 1, 5, 0, "t2_ch0");
    cycle(0, 0, 0, '0, 1, 1, 15, 0, "t2_ch1");
    cycle(0, 0, 0, '0, N, 1, 5, 0, "t2_cyc");

    cycle(0, 0, 0, '0, N + 1, 1, 0, 0, "t6_oob");
    cycle(0, 0, 0, '0, 0, 1, 5, 0, "t6_sel0");
    cycle(0, 0, 0, '0, 1, 1, 15, 0, "t6_sel1");
    cycle(0, 0, 0, '0, (1 << SW) - 1, 1, 0, 0, "t6_top");

    inc3 = '0; inc3[1:0] = 2'd3;
    cycle(0, 1, 0, '0, 0, 0, 0, 0, "t3_clr");
    cycle(1, 0, 0, inc3, 0, 0, 0, 0, "t3_start");
    repeat (85) cycle(0, 0, 0, inc3, 0, 0, 0, 0, "t3_run");
    cycle(1, 0, 0, inc3, 0, 0, 0, 0, "t3_stop");
    cycle(0, 0, 1, '0, 0, 0, 0, 0, "t3_snap");
    cycle(0, 0, 0, '0, 0, 1, SAT ? MAXV : 2, 1, "t3_ch0");

    inc1 = '0; inc1[1:0] = 2'd1;
    cycle(0, 1, 0, '0, 0, 0, 0, 0, "t4_clr");
    cycle(1, 0, 0, inc1, 0, 0, 0, 0, "t4_start");
    repeat (7) cycle(0, 0, 0, inc1, 0, 0, 0, 0, "t4_run");
    cycle(0, 1, 1, inc1, 0, 0, 0, 0, "t4_clrsnap");
    cycle(0, 0, 1, '0, 0, 1, 7, 0, "t4_shadow");
    cycle(0, 0, 0, '0, 0, 1, 0, 0, "t4_cleared");

    repeat (3) cycle(0, 0, 0, (N*IW)'($urandom), 0, 0, 0, 0, "t5_run");
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_val("t5_data", rd_data_out, '0);
    check_val("t5_rovf", OW'(rd_ovf_out), '0);
    check_val("t5_any", OW'(ovf_any_out), '0);
    check_val("t5_run", OW'(running_out), '0);
    model_reset();
    #1 reset = 1'b1;
    cycle(0, 0, 0, '1, 0, 0, 0, 0, "t5_after");
    cycle(0, 0, 1, '0, N, 1, 0, 0, "t5_cyc");

    for (int k = 0; k < 600; k++) begin
      r = (N*IW)'($urandom);
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
            r, int'($urandom_range(0, (1 << SW) - 1)), 0, 0, 0, "rnd");
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmc_counter_bank.md
Name: pmc_counter_bank

Overview:
Parametrised performance-monitor counter bank, the successor to the fixed four-counter PMC.
- Provides NUM_EVENTS independent event channels, each taking a multi-bit increment per cycle, plus a free-running enabled-cycle counter.
- Supports synchronous start/stop, clear and snapshot control, with sticky overflow flags.
- Channels are read through an indexed, zero-extended vector-width port.
- Sits beside the pipeline; fed from control/hazard signals; read by the metrics/vector write-back path.

Parameters:
NUM_EVENTS, 8, number of event channels (1..32)
CNT_W, 32, width of each live counter and shadow counter (8..64)
INC_W, 2, width of each channel's per-cycle increment (1..4)
OUT_W, 256, width of rd_data_out; must be >= CNT_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pmc_en  in  1  start/stop toggle request; one-cycle pulse, sampled on clk
clear_req  in  1  zero all live counters, cycle counter and overflow flags
snap_req  in  1  copy live counters into the shadow bank
event_inc_in  in  NUM_EVENTS*INC_W  packed per-channel increments; channel i uses bits [i*INC_W +: INC_W]
rd_sel  in  $clog2(NUM_EVENTS+1)  read index; 0..NUM_EVENTS-1 selects a channel, NUM_EVENTS selects the cycle counter
rd_data_out  out  OUT_W  shadow value of the selected counter, zero-extended to OUT_W
rd_ovf_out  out  1  sticky overflow flag of the selected counter
ovf_any_out  out  1  OR of all sticky overflow flags
running_out  out  1  high while in RUNNING

Behaviour:
- Reset (reset=0, asynchronous):
  - state=STOPPED.
  - All live counters, shadow counters, overflow flags and the cycle counter go to 0.
  - All outputs are 0.
  - A reset that arrives mid-count discards all values.
- State machine (2 states, STOPPED and RUNNING):
  - pmc_en is sampled synchronously; a level high in a cycle counts as one toggle request.
  - A request in STOPPED moves to RUNNING; a request in RUNNING moves to STOPPED.
  - Holding pmc_en high for k cycles toggles k times; upstream must pulse it.
  - running_out is registered and equals (state==RUNNING).
- Counting:
  - In RUNNING, each cycle live[i] <= live[i] + event_inc_in[i].
  - The cycle counter increments by 1 every RUNNING cycle.
  - Events presented in the same cycle as a STOPPED->RUNNING request are not counted.
  - Events presented in the same cycle as a RUNNING->STOPPED request are counted.
- Overflow:
  - Default behaviour is wrap modulo 2^CNT_W.
  - A carry out of CNT_W sets that channel's sticky ovf[i]; only clear_req or reset clears it.
- clear_req:
  - Live counters, cycle counter and ovf flags are 0 on the next cycle.
  - clear_req has priority over the increment in the same cycle.
  - Shadow counters and state are unchanged.
- snap_req:
  - shadow[i] <= live[i] as it was before this edge's update, i.e. the pre-increment value.
  - Same for the cycle counter.
- Simultaneous clear_req and snap_req: the shadow captures the pre-clear values, then the live counters clear.
- Read:
  - rd_data_out and rd_ovf_out are registered, with 1-cycle latency from rd_sel.
  - A rd_sel value above NUM_EVENTS returns 0 for both.
  - Reads always show shadow values, so software snapshots first, then reads a consistent set.
  - rd_ovf_out shows the live sticky flag.
- ovf_any_out is registered, with 1-cycle latency after the flag sets.

Optional Feature:
Macro PMC_SATURATE_EN.
- Defined: counters saturate at 2^CNT_W-1 instead of wrapping. ovf[i] sets on the first increment that would exceed the maximum; the value holds at all-ones until clear.
- Undefined: wrap-around as described above; no saturation logic is synthesised.

Decomposition:
- Package pmc_pkg holds:
  - pmc_state_t enum {PMC_STOPPED, PMC_RUNNING}
  - default parameter constants
  - function pmc_sel_w(n) returning $clog2(n+1)
- One sub-module, pmc_channel (parameters CNT_W, INC_W):
  - inputs: clk, reset, run, clear, snap, inc
  - outputs: live, shadow, ovf
  - holds the wrap/saturate logic
  - instantiated NUM_EVENTS+1 times via generate; the cycle counter is the extra instance with inc=1.
- The top holds the FSM, read mux and ovf reduction.

Test Plan:
1. Reset release, no pmc_en, event_inc_in all-ones for 10 cycles, snap, read ch0 -> rd_data_out=0, running_out=0.
2. pmc_en pulse, ch0 inc=1 and ch1 inc=3 for 5 cycles, pmc_en pulse, snap, read ch0/ch1/cycle -> 5, 15, 5 (the cycle in which the stop pulse arrives is counted).
3. CNT_W=8, ch0 inc=3 from 0 for 86 cycles -> wrap: shadow=2, rd_ovf_out=1, ovf_any_out=1. Same case with PMC_SATURATE_EN -> shadow=255, ovf=1.
4. Counting at ch0=7, assert clear_req and snap_req together -> shadow ch0=7, next snap shows 0, ovf flags cleared, running_out stays 1.
5. RUNNING with counters nonzero, drop reset for 1 cycle asynchronously (no clk edge) -> all outputs 0 immediately, state STOPPED after release.
6. rd_sel=NUM_EVENTS+1 -> rd_data_out=0 and rd_ovf_out=0 one cycle later; rd_sel change from 0 to 1 is reflected with exactly 1-cycle latency.
